// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C target register file.
package i2c_pkg;

   localparam int I2C_DW = 8;
   localparam int I2C_AW = 3;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RACK
   } state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Pad conditioning for one bus line: 2-FF synchronizer, stable-sample glitch filter
// and single-cycle edge strobes registered together with the filtered level.
module i2c_line_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

   logic [1:0]    sync_q, sync_d;
   logic          filt_q, filt_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The counter only runs while the synchronized level disagrees with the filtered
   // one, so any shorter excursion resets it and never reaches the output.
   always_comb begin
      sync_d = {sync_q[0], line_i};
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync_q[1] != filt_q) begin
         if (cnt_q == CW'(FILTER_LEN - 1)) begin
            filt_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      rise_d = filt_d & ~filt_q;
      fall_d = ~filt_d & filt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
         filt_q <= 1'b1;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         filt_q <= filt_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         cnt_q  <= cnt_d;
      end
   end

   assign level_o = filt_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with an 8x8 register file, pointer auto-increment and a local access port.
// SDA is open-drain: O_SDA_OE=1 pulls the line low.
module i2c_slave_regfile
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR   = 7'h50,
   parameter int         FILTER_LEN = 3
) (
   input  logic              I_CLK,
   input  logic              I_RESETN,
   input  logic              I_SCL,
   input  logic              I_SDA,
   output logic              O_SDA_OE,
   input  logic              I_LWE,
   input  logic [I2C_AW-1:0] I_LADDR,
   input  logic [I2C_DW-1:0] I_LWDATA,
   output logic [I2C_DW-1:0] O_LRDATA,
   output logic              O_INT,
   output logic              O_BUSY,
   output state_t            O_DBG_STATE
);

   localparam int NREG = 1 << I2C_AW;

   logic              scl_f, scl_rise, scl_fall;
   logic              sda_f, sda_rise, sda_fall;
   logic              start_det, stop_det;
   state_t            state_q, state_d;
   logic [2:0]        bitcnt_q, bitcnt_d;
   logic [I2C_DW-1:0] shift_q, shift_d;
   logic [I2C_AW-1:0] ptr_q, ptr_d, ptr_inc;
   logic              rw_q, rw_d;
   logic              phase_q, phase_d;
   logic              oe_q, oe_d;
   logic              wrote_q, wrote_d;
   logic              busy_q, busy_d;
   logic              int_q, int_d;
   logic [I2C_DW-1:0] regs_q [NREG];
   logic [I2C_DW-1:0] regs_d [NREG];
   logic [I2C_DW-1:0] lrdata_q, lrdata_d;
   logic [I2C_DW-1:0] byte_in, rd_byte;
   logic              bus_we;

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
      .clk(I_CLK), .rst_n(I_RESETN), .line_i(I_SCL),
      .level_o(scl_f), .rise_o(scl_rise), .fall_o(scl_fall)
   );

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
      .clk(I_CLK), .rst_n(I_RESETN), .line_i(I_SDA),
      .level_o(sda_f), .rise_o(sda_rise), .fall_o(sda_fall)
   );

   assign start_det = sda_fall & scl_f;
   assign stop_det  = sda_rise & scl_f;

   // phase_q: in ACK states it marks "ACK is being driven"; in RDATA it marks
   // "all 8 bits are on the wire, the next scl_fall releases SDA".
   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      ptr_d    = ptr_q;
      rw_d     = rw_q;
      phase_d  = phase_q;
      oe_d     = oe_q;
      wrote_d  = wrote_q;
      busy_d   = busy_q;
      int_d    = 1'b0;
      bus_we   = 1'b0;
      byte_in  = {shift_q[I2C_DW-2:0], sda_f};
      rd_byte  = regs_q[ptr_q];
      ptr_inc  = ptr_q + I2C_AW'(1);

      if (start_det) begin
         state_d  = ADDR;
         bitcnt_d = '0;
         wrote_d  = 1'b0;
         phase_d  = 1'b0;
         oe_d     = 1'b0;
      end else if (stop_det) begin
         state_d = IDLE;
         int_d   = wrote_q;
         wrote_d = 1'b0;
         phase_d = 1'b0;
         oe_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE: ;
            ADDR, PTR, WDATA: begin
               if (scl_rise) begin
                  shift_d  = byte_in;
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) begin
                     phase_d = 1'b0;
                     if (state_q == ADDR) begin
                        if (byte_in[7:1] == DEV_ADDR) begin
                           state_d = ADDR_ACK;
                           rw_d    = byte_in[0];
                           busy_d  = 1'b1;
                        end else begin
                           state_d = IDLE;
                        end
                     end else if (state_q == PTR) begin
                        ptr_d   = byte_in[I2C_AW-1:0];
                        state_d = PTR_ACK;
                     end else begin
                        bus_we  = 1'b1;
                        ptr_d   = ptr_inc;
                        wrote_d = 1'b1;
                        state_d = WDATA_ACK;
                     end
                  end
               end
            end
            ADDR_ACK, PTR_ACK, WDATA_ACK: begin
               if (scl_fall) begin
                  if (!phase_q) begin
                     oe_d    = 1'b1;
                     phase_d = 1'b1;
                  end else begin
                     oe_d     = 1'b0;
                     phase_d  = 1'b0;
                     bitcnt_d = '0;
                     if (state_q != ADDR_ACK) begin
                        state_d = WDATA;
                     end else if (!rw_q) begin
                        state_d = PTR;
                     end else begin
                        // The fall that ends the ACK also puts the first read bit out.
                        state_d  = RDATA;
                        oe_d     = ~rd_byte[I2C_DW-1];
                        shift_d  = {rd_byte[I2C_DW-2:0], 1'b0};
                        bitcnt_d = 3'd1;
                     end
                  end
               end
            end
            RDATA: begin
               if (scl_fall) begin
                  if (phase_q) begin
                     oe_d    = 1'b0;
                     phase_d = 1'b0;
                     state_d = RACK;
                  end else begin
                     oe_d     = ~shift_q[I2C_DW-1];
                     shift_d  = {shift_q[I2C_DW-2:0], 1'b0};
                     bitcnt_d = bitcnt_q + 3'd1;
                     phase_d  = (bitcnt_q == 3'd7);
                  end
               end
            end
            RACK: begin
               if (scl_rise) begin
                  if (!sda_f) begin
                     ptr_d    = ptr_inc;
                     shift_d  = regs_q[ptr_inc];
                     bitcnt_d = '0;
                     state_d  = RDATA;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (state_d == IDLE) begin
         busy_d = 1'b0;
      end
   end

   // Local write lands first so a same-cycle bus write to the same register wins.
   always_comb begin
      regs_d = regs_q;
      if (I_LWE) begin
         regs_d[I_LADDR] = I_LWDATA;
      end
      if (bus_we) begin
         regs_d[ptr_q] = byte_in;
      end
      lrdata_d = regs_q[I_LADDR];
   end

   always_ff @(posedge I_CLK or negedge I_RESETN) begin
      if (!I_RESETN) begin
         state_q  <= IDLE;
         bitcnt_q <= '0;
         shift_q  <= '0;
         ptr_q    <= '0;
         rw_q     <= 1'b0;
         phase_q  <= 1'b0;
         oe_q     <= 1'b0;
         wrote_q  <= 1'b0;
         busy_q   <= 1'b0;
         int_q    <= 1'b0;
         lrdata_q <= '0;
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         ptr_q    <= ptr_d;
         rw_q     <= rw_d;
         phase_q  <= phase_d;
         oe_q     <= oe_d;
         wrote_q  <= wrote_d;
         busy_q   <= busy_d;
         int_q    <= int_d;
         lrdata_q <= lrdata_d;
         regs_q   <= regs_d;
      end
   end

   assign O_SDA_OE    = oe_q;
   assign O_INT       = int_q;
   assign O_BUSY      = busy_q;
   assign O_LRDATA    = lrdata_q;
   assign O_DBG_STATE = state_q;

endmodule
